// File: rtl/apb_pkg.sv
// Shared APB definitions: bus geometry, alignment helper and requester state encoding.
package apb_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int ALIGNBITS       = 2;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_SETUP,
        REQ_ACCESS,
        REQ_RESP
    } req_state_e;

    function automatic logic validAlign(input logic [ADDR_WIDTH-1:0] addr);
        return (addr & {{(ADDR_WIDTH-ALIGNBITS){1'b0}}, {ALIGNBITS{1'b1}}}) == '0;
    endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter; saturates instead of wrapping, expiry disabled when TIMEOUT is 0.
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned LIMIT = (TIMEOUT == 0) ? 1 : TIMEOUT;
    localparam int unsigned LAST  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [CW-1:0] count;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CW'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    // Flags the last permitted ACCESS cycle so the FSM leaves on that edge.
    assign expired = (TIMEOUT != 0) && (count == CW'(LAST));

endmodule

// File: rtl/apb_requester.sv
// APB requester: one transfer per command, with misalignment check and ACCESS timeout.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = apb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int PKG_AW = apb_pkg::ADDR_WIDTH;

    req_state_e        state, next_state;
    logic              accept;
    logic              aligned;
    logic              tmo_expired;
    logic [PKG_AW-1:0] align_addr;

    assign align_addr = PKG_AW'(cmd_addr);
    assign aligned    = validAlign(align_addr);
    assign accept     = cmd_valid && cmd_ready && (state == REQ_IDLE);

    apb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (next_state == REQ_SETUP),
        .inc     (state == REQ_ACCESS),
        .expired (tmo_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= REQ_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            REQ_IDLE:   if (accept) next_state = aligned ? REQ_SETUP : REQ_RESP;
            REQ_SETUP:  next_state = REQ_ACCESS;
            REQ_ACCESS: if (pready || tmo_expired) next_state = REQ_RESP;
            REQ_RESP:   if (rsp_ready) next_state = REQ_IDLE;
            default:    next_state = REQ_IDLE;
        endcase
    end

    // Handshake/bus strobes are registered from next_state so reset holds them all at 0.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            cmd_ready <= (next_state == REQ_IDLE);
            psel      <= (next_state == REQ_SETUP) || (next_state == REQ_ACCESS);
            penable   <= (next_state == REQ_ACCESS);
            rsp_valid <= (next_state == REQ_RESP);
            if (accept) begin
                pwrite      <= cmd_write;
                paddr       <= cmd_addr;
                pwdata      <= cmd_wdata;
                rsp_rdata   <= '0;
                rsp_err     <= !aligned;
                rsp_timeout <= 1'b0;
            end
            if (state == REQ_ACCESS) begin
                if (pready) begin
                    rsp_err   <= pslverr;
                    rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
                end else if (tmo_expired) begin
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                    rsp_rdata   <= '0;
                end
            end
        end
    end

endmodule
